// File: rtl/web_resource_pool.sv
// web_resource_pool: multi-channel resource pool that arbitrates fire and refill requests.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fire_req, refill_req       level requests (held until serviced, then dropped)
//   refill_mask                channels loaded by a refill
//   cost, refill_level         packed per-channel cost / refill value (WIDTH bits each)
//   level                      packed per-channel current levels
//   fire_ack, fire_nack        one-cycle shot result pulses
//   short                      channels insufficient at the last check
//   empty                      per-channel level == 0
//   busy, dead                 state != IDLE, sticky kill flag (channel 0 drained by a shot)
// Optional feature: define WEB_POOL_AUTOREGEN_EN to regenerate channel 0 by one
// unit every REGEN_PERIOD idle cycles (saturating).
module web_resource_pool #(
   parameter int CHANNELS     = 3,
   parameter int WIDTH        = 9,
   parameter int REGEN_PERIOD = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      fire_req,
   input  logic                      refill_req,
   input  logic [CHANNELS-1:0]       refill_mask,
   input  logic [CHANNELS*WIDTH-1:0] cost,
   input  logic [CHANNELS*WIDTH-1:0] refill_level,
   output logic [CHANNELS*WIDTH-1:0] level,
   output logic                      fire_ack,
   output logic                      fire_nack,
   output logic [CHANNELS-1:0]       short,
   output logic [CHANNELS-1:0]       empty,
   output logic                      busy,
   output logic                      dead
);
   typedef enum logic [2:0] {IDLE, CHECK, REFILL, WAIT_REL, DEAD} state_t;
   state_t                    state_q, state_d;
   logic [CHANNELS*WIDTH-1:0] level_q, level_d, cost_q, cost_d, debit;
   logic [CHANNELS-1:0]       short_q, short_d, ok;
   logic                      fire_ack_q, fire_ack_d, fire_nack_q, fire_nack_d, dead_q, dead_d;
`ifdef WEB_POOL_AUTOREGEN_EN
   localparam int CW = REGEN_PERIOD > 1 ? $clog2(REGEN_PERIOD) : 1;
   logic [CW-1:0] regen_q, regen_d;
   logic          regen_wrap;
   assign regen_wrap = regen_q == CW'(REGEN_PERIOD - 1);
`endif
   // Subtraction results are only committed when every channel passed the check.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         ok[i] = level_q[i*WIDTH +: WIDTH] >= cost_q[i*WIDTH +: WIDTH];
         debit[i*WIDTH +: WIDTH] = level_q[i*WIDTH +: WIDTH] - cost_q[i*WIDTH +: WIDTH];
         empty[i] = level_q[i*WIDTH +: WIDTH] == '0;
      end
   end
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      cost_d      = cost_q;
      short_d     = short_q;
      dead_d      = dead_q;
      fire_ack_d  = 1'b0;
      fire_nack_d = 1'b0;
      case (state_q)
         IDLE:
            if (fire_req && !refill_req) begin
               cost_d  = cost;
               state_d = CHECK;
            end else if (refill_req && !fire_req) begin
               state_d = REFILL;
            end
         CHECK: begin
            short_d = ~ok;
            if (&ok) begin
               level_d    = debit;
               fire_ack_d = 1'b1;
               dead_d     = debit[WIDTH-1:0] == '0;
               state_d    = debit[WIDTH-1:0] == '0 ? DEAD : WAIT_REL;
            end else begin
               fire_nack_d = 1'b1;
               state_d     = WAIT_REL;
            end
         end
         REFILL: begin
            for (int i = 0; i < CHANNELS; i++)
               if (refill_mask[i]) level_d[i*WIDTH +: WIDTH] = refill_level[i*WIDTH +: WIDTH];
            state_d = WAIT_REL;
         end
         WAIT_REL:
            if (!fire_req && !refill_req) state_d = IDLE;
         DEAD: ;
         default: state_d = IDLE;
      endcase
`ifdef WEB_POOL_AUTOREGEN_EN
      // Counter only runs while staying in IDLE; any departure restarts it.
      regen_d = (state_q == IDLE && state_d == IDLE) ? (regen_wrap ? '0 : regen_q + 1'b1) : '0;
      if (state_q == IDLE && regen_wrap && level_q[WIDTH-1:0] != '1)
         level_d[WIDTH-1:0] = level_q[WIDTH-1:0] + 1'b1;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         level_q     <= '0;
         cost_q      <= '0;
         short_q     <= '0;
         dead_q      <= 1'b0;
         fire_ack_q  <= 1'b0;
         fire_nack_q <= 1'b0;
`ifdef WEB_POOL_AUTOREGEN_EN
         regen_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         cost_q      <= cost_d;
         short_q     <= short_d;
         dead_q      <= dead_d;
         fire_ack_q  <= fire_ack_d;
         fire_nack_q <= fire_nack_d;
`ifdef WEB_POOL_AUTOREGEN_EN
         regen_q     <= regen_d;
`endif
      end
   end
   assign level     = level_q;
   assign fire_ack  = fire_ack_q;
   assign fire_nack = fire_nack_q;
   assign short     = short_q;
   assign busy      = state_q != IDLE;
   assign dead      = dead_q;
endmodule

// File: tb/tb_web_resource_pool.sv
// tb_web_resource_pool: directed self-checking bench for web_resource_pool.
module tb_web_resource_pool;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fire_req = 1'b0;
   logic        refill_req = 1'b0;
   logic [2:0]  refill_mask = '0;
   logic [26:0] cost = '0;
   logic [26:0] refill_level = '0;
   logic [26:0] level;
   logic        fire_ack, fire_nack, busy, dead;
   logic [2:0]  short, empty;
   int          checks = 0;
   int          errors = 0;

   web_resource_pool #(.CHANNELS(3), .WIDTH(9), .REGEN_PERIOD(8)) dut (
      .clk(clk), .rst_n(rst_n), .fire_req(fire_req), .refill_req(refill_req),
      .refill_mask(refill_mask), .cost(cost), .refill_level(refill_level),
      .level(level), .fire_ack(fire_ack), .fire_nack(fire_nack), .short(short),
      .empty(empty), .busy(busy), .dead(dead)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_refill(input logic [2:0] m, input logic [26:0] v);
      refill_mask = m;
      refill_level = v;
      refill_req = 1'b1;
      cyc();
      cyc();
      refill_req = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      #2;
      checks++; if (level !== 27'd0) begin errors++; $display("FAIL reset_level got %h want 0", level); end
      checks++; if ({fire_ack, fire_nack, busy, dead} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {fire_ack, fire_nack, busy, dead}); end
      checks++; if (short !== 3'b000 || empty !== 3'b111) begin errors++; $display("FAIL reset_short_empty got %b/%b want 000/111", short, empty); end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_refill();
      logic seen = 1'b0;
      refill_mask = 3'b111;
      refill_level = {9'd1, 9'd256, 9'd16};
      refill_req = 1'b1;
      cyc();
      seen |= fire_ack | fire_nack;
      checks++; if (busy !== 1'b1 || level !== 27'd0) begin errors++; $display("FAIL refill_pending got busy=%b level=%h want 1/0", busy, level); end
      cyc();
      seen |= fire_ack | fire_nack;
      checks++; if (level !== {9'd1, 9'd256, 9'd16}) begin errors++; $display("FAIL refill_level got %h want %h", level, {9'd1, 9'd256, 9'd16}); end
      refill_req = 1'b0;
      cyc();
      seen |= fire_ack | fire_nack;
      checks++; if (busy !== 1'b0 || seen !== 1'b0) begin errors++; $display("FAIL refill_release got busy=%b pulse=%b want 0/0", busy, seen); end
   endtask

   task automatic test_nack();
      cost = {9'd4, 9'd1, 9'd1};
      fire_req = 1'b1;
      cyc();
      cost = {9'd0, 9'd1, 9'd1};
      checks++; if ({fire_ack, fire_nack} !== 2'b00) begin errors++; $display("FAIL nack_early got %b want 00", {fire_ack, fire_nack}); end
      cyc();
      checks++; if ({fire_ack, fire_nack} !== 2'b01) begin errors++; $display("FAIL nack_pulse got %b want 01", {fire_ack, fire_nack}); end
      checks++; if (short !== 3'b100 || level !== {9'd1, 9'd256, 9'd16}) begin errors++; $display("FAIL nack_state got short=%b level=%h want 100/%h", short, level, {9'd1, 9'd256, 9'd16}); end
      fire_req = 1'b0;
      cyc();
      checks++; if ({fire_nack, busy} !== 2'b00) begin errors++; $display("FAIL nack_release got %b want 00", {fire_nack, busy}); end
   endtask

   task automatic test_ack();
      cost = {9'd0, 9'd1, 9'd1};
      fire_req = 1'b1;
      cyc();
      checks++; if (fire_ack !== 1'b0) begin errors++; $display("FAIL ack_early got %b want 0", fire_ack); end
      cyc();
      checks++; if ({fire_ack, fire_nack} !== 2'b10 || level !== {9'd1, 9'd255, 9'd15} || short !== 3'b000) begin errors++; $display("FAIL ack_result got ack/nack=%b level=%h short=%b want 10/%h/000", {fire_ack, fire_nack}, level, short, {9'd1, 9'd255, 9'd15}); end
      fire_req = 1'b0;
      cyc();
      checks++; if (fire_ack !== 1'b0) begin errors++; $display("FAIL ack_single got %b want 0", fire_ack); end
   endtask

   task automatic test_hold();
      int acks = 0;
      cost = {9'd0, 9'd0, 9'd1};
      fire_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         acks += int'(fire_ack);
      end
      checks++; if (acks !== 1 || level[8:0] !== 9'd14) begin errors++; $display("FAIL hold_once got acks=%0d lvl0=%0d want 1/14", acks, level[8:0]); end
      fire_req = 1'b0;
      cyc();
      fire_req = 1'b1;
      cyc();
      cyc();
      checks++; if (fire_ack !== 1'b1 || level[8:0] !== 9'd13) begin errors++; $display("FAIL hold_reassert got ack=%b lvl0=%0d want 1/13", fire_ack, level[8:0]); end
      fire_req = 1'b0;
      cyc();
   endtask

   task automatic test_partial_refill();
      do_refill(3'b001, {9'd100, 9'd100, 9'd5});
      checks++; if (level !== {9'd1, 9'd255, 9'd5}) begin errors++; $display("FAIL mask_refill got %h want %h", level, {9'd1, 9'd255, 9'd5}); end
   endtask

   task automatic test_dead();
      logic seen = 1'b0;
      cost = {9'd0, 9'd0, 9'd5};
      fire_req = 1'b1;
      cyc();
      cyc();
      checks++; if ({fire_ack, dead, busy} !== 3'b111 || level !== {9'd1, 9'd255, 9'd0} || empty !== 3'b001) begin errors++; $display("FAIL dead_kill got ack/dead/busy=%b level=%h empty=%b want 111/%h/001", {fire_ack, dead, busy}, level, empty, {9'd1, 9'd255, 9'd0}); end
      fire_req = 1'b0;
      cyc();
      refill_mask = 3'b111;
      refill_level = {9'd50, 9'd50, 9'd50};
      refill_req = 1'b1;
      for (int i = 0; i < 4; i++) begin cyc(); seen |= fire_ack | fire_nack; end
      refill_req = 1'b0;
      fire_req = 1'b1;
      for (int i = 0; i < 4; i++) begin cyc(); seen |= fire_ack | fire_nack; end
      fire_req = 1'b0;
      checks++; if (seen !== 1'b0 || dead !== 1'b1 || level !== {9'd1, 9'd255, 9'd0}) begin errors++; $display("FAIL dead_frozen got pulse=%b dead=%b level=%h want 0/1/%h", seen, dead, level, {9'd1, 9'd255, 9'd0}); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (level !== 27'd0 || dead !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dead_reset got level=%h dead=%b busy=%b want 0/0/0", level, dead, busy); end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_abort();
      refill_mask = 3'b111;
      refill_level = {9'd7, 9'd7, 9'd7};
      refill_req = 1'b1;
      cyc();
      rst_n = 1'b0;
      cyc();
      refill_req = 1'b0;
      rst_n = 1'b1;
      cyc();
      checks++; if (level !== 27'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_refill got level=%h busy=%b want 0/0", level, busy); end
   endtask

`ifdef WEB_POOL_AUTOREGEN_EN
   task automatic test_regen();
      refill_mask = 3'b001;
      refill_level = {9'd0, 9'd0, 9'd10};
      refill_req = 1'b1;
      cyc();
      cyc();
      refill_req = 1'b0;
      cyc();
      for (int i = 0; i < 80; i++) cyc();
      checks++; if (level[8:0] !== 9'd20) begin errors++; $display("FAIL regen_count got %0d want 20", level[8:0]); end
      refill_level = {9'd0, 9'd0, 9'd511};
      refill_req = 1'b1;
      cyc();
      cyc();
      refill_req = 1'b0;
      cyc();
      for (int i = 0; i < 24; i++) cyc();
      checks++; if (level[8:0] !== 9'd511) begin errors++; $display("FAIL regen_sat got %0d want 511", level[8:0]); end
   endtask
`else
   task automatic test_regen();
      do_refill(3'b001, {9'd0, 9'd0, 9'd10});
      for (int i = 0; i < 40; i++) cyc();
      checks++; if (level !== {9'd0, 9'd0, 9'd10}) begin errors++; $display("FAIL no_regen got %h want %h", level, {9'd0, 9'd0, 9'd10}); end
   endtask
`endif

   initial begin
      test_reset();
      test_refill();
      test_nack();
      test_ack();
      test_hold();
      test_partial_refill();
      test_dead();
      test_abort();
      test_regen();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
